// File: rtl/sys_ctrl_uart_bridge.sv
// rtl/sys_ctrl_uart_bridge.sv - UART host bridge: CPU halt/run/reset and halted-bus memory read/write.
// Define SYS_CTRL_WRITE_ACK_EN to reply 0xAA (0xEE if dropped) after every WRITE command.
module sys_ctrl_uart_bridge #(
  parameter int CLKS_PER_BIT   = 87,
  parameter int TIMEOUT_CLKS   = 100000,
  parameter int CPU_RST_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic [15:0] cpu_addr,
  output logic [7:0]  cpu_wdata,
  input  logic [7:0]  cpu_rdata,
  output logic        write_en,
  output logic        read_en,
  output logic        cpu_halt,
  output logic        cpu_rst,
  input  logic        cpu_is_halted
);

  localparam int BW = $clog2(CLKS_PER_BIT + 1);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam int RW = $clog2(CPU_RST_CYCLES + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);
  localparam logic [RW-1:0] RST_LAST  = RW'(CPU_RST_CYCLES - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] GET_AH   = 4'd1;
  localparam logic [3:0] GET_AL   = 4'd2;
  localparam logic [3:0] GET_DATA = 4'd3;
  localparam logic [3:0] MEM_WR   = 4'd4;
  localparam logic [3:0] MEM_RD   = 4'd5;
  localparam logic [3:0] RD_WAIT  = 4'd6;
  localparam logic [3:0] TX_SEND  = 4'd7;
  localparam logic [3:0] TX_WAIT  = 4'd8;
  localparam logic [3:0] RST_HOLD = 4'd9;

  logic          rx_meta, rx_sync, rx_prev;
  logic [1:0]    rx_state;
  logic [BW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic [7:0]    rx_data;
  logic          rx_valid;

  logic          tx_busy;
  logic [BW-1:0] tx_cnt;
  logic [3:0]    tx_bitn;
  logic [8:0]    tx_shift;
  logic          tx_start;

  logic [3:0]    state;
  logic [7:0]    addr_hi, addr_lo;
  logic          is_read;
  logic          rd_ok;
  logic [7:0]    reply;
  logic [TW-1:0] to_cnt;
  logic          to_hit;
  logic [RW-1:0] rst_cnt;

  // Receiver: frame starts on a falling edge, start bit re-checked half a bit later.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_meta  <= uart_rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign tx_start = (state == TX_SEND);

  // Transmitter: busy stays high until the full stop bit has been driven.
  always_ff @(posedge clk) begin
    if (rst) begin
      uart_tx  <= 1'b1;
      tx_busy  <= 1'b0;
      tx_cnt   <= '0;
      tx_bitn  <= '0;
      tx_shift <= '0;
    end else if (!tx_busy) begin
      if (tx_start) begin
        uart_tx  <= 1'b0;
        tx_shift <= {1'b1, reply};
        tx_busy  <= 1'b1;
        tx_cnt   <= '0;
        tx_bitn  <= '0;
      end
    end else if (tx_cnt == BIT_LAST) begin
      tx_cnt <= '0;
      if (tx_bitn == 4'd9) begin
        tx_busy <= 1'b0;
      end else begin
        uart_tx  <= tx_shift[0];
        tx_shift <= {1'b1, tx_shift[8:1]};
        tx_bitn  <= tx_bitn + 1'b1;
      end
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
    end
  end

  assign to_hit   = (to_cnt == TO_LAST);
  assign write_en = (state == MEM_WR) && cpu_is_halted;
  assign read_en  = (state == MEM_RD) && cpu_is_halted;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cpu_addr  <= '0;
      cpu_wdata <= '0;
      cpu_halt  <= 1'b0;
      cpu_rst   <= 1'b0;
      addr_hi   <= '0;
      addr_lo   <= '0;
      is_read   <= 1'b0;
      rd_ok     <= 1'b0;
      reply     <= '0;
      to_cnt    <= '0;
      rst_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_valid) begin
            case (rx_data)
              8'h00: cpu_halt <= 1'b1;
              8'h01: cpu_halt <= 1'b0;
              8'h02: begin
                is_read <= 1'b0;
                to_cnt  <= '0;
                state   <= GET_AH;
              end
              8'h03: begin
                is_read <= 1'b1;
                to_cnt  <= '0;
                state   <= GET_AH;
              end
              8'h04: begin
                cpu_rst <= 1'b1;
                rst_cnt <= '0;
                state   <= RST_HOLD;
              end
              default: state <= IDLE;
            endcase
          end
        end
        GET_AH: begin
          if (rx_valid) begin
            addr_hi <= rx_data;
            to_cnt  <= '0;
            state   <= GET_AL;
          end else if (to_hit) begin
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        GET_AL: begin
          if (rx_valid) begin
            to_cnt <= '0;
            if (is_read) begin
              cpu_addr <= {addr_hi, rx_data};
              state    <= MEM_RD;
            end else begin
              addr_lo <= rx_data;
              state   <= GET_DATA;
            end
          end else if (to_hit) begin
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        GET_DATA: begin
          if (rx_valid) begin
            cpu_addr  <= {addr_hi, addr_lo};
            cpu_wdata <= rx_data;
            state     <= MEM_WR;
          end else if (to_hit) begin
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        MEM_WR: begin
`ifdef SYS_CTRL_WRITE_ACK_EN
          reply <= cpu_is_halted ? 8'hAA : 8'hEE;
          state <= TX_SEND;
`else
          state <= IDLE;
`endif
        end
        MEM_RD: begin
          rd_ok <= cpu_is_halted;
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          // Bus not granted: reply zero so the host still gets its one byte.
          reply <= rd_ok ? cpu_rdata : 8'h00;
          state <= TX_SEND;
        end
        TX_SEND: state <= TX_WAIT;
        TX_WAIT: begin
          if (!tx_busy) state <= IDLE;
        end
        RST_HOLD: begin
          if (rst_cnt == RST_LAST) begin
            cpu_rst <= 1'b0;
            state   <= IDLE;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_ctrl_uart_bridge.sv
// tb/tb_sys_ctrl_uart_bridge.sv - randomized bench for sys_ctrl_uart_bridge against a command-level memory model.
module tb_sys_ctrl_uart_bridge;

  localparam int CPB  = 8;
  localparam int TOC  = 400;
  localparam int RSTC = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_rx;
  logic        uart_tx;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata = 8'h00;
  logic        write_en, read_en, cpu_halt, cpu_rst;
  logic        cpu_is_halted;

  always #5 clk = ~clk;

  sys_ctrl_uart_bridge #(
    .CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TOC), .CPU_RST_CYCLES(RSTC)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .write_en(write_en), .read_en(read_en), .cpu_halt(cpu_halt),
    .cpu_rst(cpu_rst), .cpu_is_halted(cpu_is_halted)
  );

  logic [7:0]  ram [0:65535];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          rst_hi = 0;
  logic [15:0] last_waddr = '0;
  logic [7:0]  last_wdata = '0;

  always @(posedge clk) begin
    if (write_en) begin
      ram[cpu_addr] <= cpu_wdata;
      wr_cnt        <= wr_cnt + 1;
      last_waddr    <= cpu_addr;
      last_wdata    <= cpu_wdata;
    end
    if (read_en) begin
      cpu_rdata <= ram[cpu_addr];
      rd_cnt    <= rd_cnt + 1;
    end
    if (cpu_rst) rst_hi <= rst_hi + 1;
  end

  // Reference model: what memory holds after the accepted writes, and the halt request level.
  logic [7:0] exp_mem [int];
  logic       model_halt = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_rd(input logic [15:0] a, input logic halted);
    if (!halted) return 8'h00;
    return exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : 8'h00;
  endfunction

  task automatic uart_send(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic uart_recv(output logic [7:0] b, output logic ok);
    int n;
    n  = 0;
    b  = '0;
    ok = 1'b0;
    while (uart_tx !== 1'b0 && n < 40 * CPB) begin
      @(negedge clk);
      n++;
    end
    if (uart_tx !== 1'b0) return;
    repeat (CPB / 2) @(negedge clk);
    if (uart_tx !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = uart_tx;
    end
    repeat (CPB) @(negedge clk);
    ok = (uart_tx === 1'b1);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    uart_send(c);
    repeat (4) @(negedge clk);
    if (c == 8'h00) model_halt = 1'b1;
    if (c == 8'h01) model_halt = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input logic h);
    int w0;
    w0 = wr_cnt;
    cpu_is_halted = h;
    uart_send(8'h02);
    uart_send(a[15:8]);
    uart_send(a[7:0]);
`ifdef SYS_CTRL_WRITE_ACK_EN
    begin
      logic [7:0] ack;
      logic       ok;
      fork
        uart_send(d);
        uart_recv(ack, ok);
      join
      check_eq("wr_ack_frame", 32'(ok), 32'd1);
      check_eq("wr_ack", 32'(ack), h ? 32'hAA : 32'hEE);
    end
`else
    uart_send(d);
`endif
    repeat (4) @(negedge clk);
    check_eq("wr_strobes", 32'(wr_cnt - w0), 32'(h));
    if (h) begin
      check_eq("wr_addr", 32'(last_waddr), 32'(a));
      check_eq("wr_data", 32'(last_wdata), 32'(d));
      exp_mem[int'(a)] = d;
    end
    check_eq("halt_hold_wr", 32'(cpu_halt), 32'(model_halt));
  endtask

  task automatic do_read(input logic [15:0] a, input logic h);
    int         r0;
    logic [7:0] got;
    logic       ok;
    r0 = rd_cnt;
    cpu_is_halted = h;
    uart_send(8'h03);
    uart_send(a[15:8]);
    fork
      uart_send(a[7:0]);
      uart_recv(got, ok);
    join
    check_eq("rd_frame", 32'(ok), 32'd1);
    check_eq("rd_data", 32'(got), 32'(model_rd(a, h)));
    check_eq("rd_strobes", 32'(rd_cnt - r0), 32'(h));
    check_eq("halt_hold_rd", 32'(cpu_halt), 32'(model_halt));
    repeat (CPB) @(negedge clk);
  endtask

  initial begin
    logic [15:0] pool [8];
    int          w0, r0, h0, n;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    rst = 1'b1;
    uart_rx = 1'b1;
    cpu_is_halted = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("rst_uart_tx", 32'(uart_tx), 32'd1);
    check_eq("rst_write_en", 32'(write_en), 32'd0);
    check_eq("rst_read_en", 32'(read_en), 32'd0);
    check_eq("rst_cpu_halt", 32'(cpu_halt), 32'd0);
    check_eq("rst_cpu_rst", 32'(cpu_rst), 32'd0);
    check_eq("rst_cpu_addr", 32'(cpu_addr), 32'd0);
    check_eq("rst_cpu_wdata", 32'(cpu_wdata), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    send_cmd(8'h00);
    check_eq("halt_cmd", 32'(cpu_halt), 32'(model_halt));

    do_write(16'h0037, 8'h37, 1'b1);

    for (int i = 0; i < 48; i++) do_write(16'(i), 8'(i), 1'b1);
    for (int i = 0; i < 48; i++) do_read(16'(i), 1'b1);

    do_write(16'hFFFF, 8'h5A, 1'b1);
    do_read(16'hFFFF, 1'b1);

    w0 = wr_cnt;
    r0 = rd_cnt;
    send_cmd(8'h7E);
    check_eq("bad_cmd_strobes", 32'(wr_cnt - w0 + rd_cnt - r0), 32'd0);
    check_eq("bad_cmd_halt", 32'(cpu_halt), 32'(model_halt));

    pool[0] = 16'hFFFF;
    pool[1] = 16'h0000;
    for (int i = 2; i < 8; i++) pool[i] = 16'($urandom);
    for (int k = 0; k < 24; k++) begin
      logic [15:0] a;
      logic        h;
      a = pool[$urandom_range(0, 7)];
      h = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) do_write(a, 8'($urandom_range(0, 255)), h);
      else                           do_read(a, h);
    end

    h0 = rst_hi;
    send_cmd(8'h04);
    repeat (RSTC + 8) @(negedge clk);
    check_eq("cpu_rst_len", 32'(rst_hi - h0), 32'(RSTC));

    send_cmd(8'h01);
    check_eq("run_cmd", 32'(cpu_halt), 32'(model_halt));

    do_write(16'h0040, 8'h99, 1'b0);
    do_read(16'h0037, 1'b0);
    do_read(16'h0037, 1'b1);

    do_write(16'h1234, 8'hC3, 1'b1);
    w0 = wr_cnt;
    r0 = rd_cnt;
    uart_send(8'h02);
    uart_send(8'h12);
    repeat (TOC + 40) @(negedge clk);
    check_eq("timeout_strobes", 32'(wr_cnt - w0 + rd_cnt - r0), 32'd0);
    do_read(16'h1234, 1'b1);

    // Reset while the reply's start bit is on the line.
    cpu_is_halted = 1'b1;
    uart_send(8'h03);
    uart_send(8'h00);
    n = 0;
    fork
      uart_send(8'h05);
      while (uart_tx !== 1'b0 && n < 40 * CPB) begin
        @(negedge clk);
        n++;
      end
    join
    check_eq("rst_mid_tx_started", 32'(uart_tx), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_uart_tx", 32'(uart_tx), 32'd1);
    check_eq("rst_mid_halt", 32'(cpu_halt), 32'd0);
    model_halt = 1'b0;
    rst = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    do_read(16'h0005, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
